// File: rtl/fpu_multicycle_controller_pkg.sv
// Shared FPU definitions: opcodes, controller state encoding, reciprocal
// pass length default and common float constants.
package fpu_multicycle_controller_pkg;

    localparam logic [1:0] FOP_ADD = 2'd0;
    localparam logic [1:0] FOP_SUB = 2'd1;
    localparam logic [1:0] FOP_MUL = 2'd2;
    localparam logic [1:0] FOP_RCP = 2'd3;

    // Default reciprocal pass length; must match the client's step-counter wrap.
    localparam int RCP_CYCLES_DEF = 8;

    // IEEE-754 single 1.0
    localparam logic [31:0] FP_ONE = 32'h3F80_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RCP  = 2'd2
    } state_e;

endpackage

// File: rtl/fpu_multicycle_controller_operand_mux.sv
// fpu_operand_mux: selects who drives the shared adder and multiplier.
// Controller latches drive the units except while the reciprocal client
// owns them. The adder and multiplier selects sit in separate blocks so the
// client's adder->multiplier chaining does not form a false block-level loop.
module fpu_operand_mux #(
    parameter int BITS = 32
) (
    input  logic            sel_client,
    input  logic [BITS-1:0] fa_l,
    input  logic [BITS-1:0] fb_l,
    input  logic            sub_l,
    input  logic [BITS-1:0] rcp_fadd_a,
    input  logic [BITS-1:0] rcp_fadd_b,
    input  logic [BITS-1:0] rcp_fmul_a,
    input  logic [BITS-1:0] rcp_fmul_b,
    output logic [BITS-1:0] add_a,
    output logic [BITS-1:0] add_b,
    output logic            add_sub,
    output logic [BITS-1:0] mul_a,
    output logic [BITS-1:0] mul_b
);

    // Adder ports: client requests (always add) or latched operands.
    always_comb begin
        if (sel_client) begin
            add_a   = rcp_fadd_a;
            add_b   = rcp_fadd_b;
            add_sub = 1'b0;
        end else begin
            add_a   = fa_l;
            add_b   = fb_l;
            add_sub = sub_l;
        end
    end

    // Multiplier ports: client requests or latched operands.
    always_comb begin
        if (sel_client) begin
            mul_a = rcp_fmul_a;
            mul_b = rcp_fmul_b;
        end else begin
            mul_a = fa_l;
            mul_b = fb_l;
        end
    end

endmodule

// File: rtl/fpu_multicycle_controller.sv
// fpu_multicycle_controller: owns the shared float adder and multiplier.
// add/sub/mul finish one edge after accept; reciprocal hands both units to
// the micro-sequencer client for one RCP_CYCLES-step pass.
// Optional macro FPU_BACK_TO_BACK_EN: accept a start in the done cycle.
module fpu_multicycle_controller
    import fpu_multicycle_controller_pkg::*;
#(
    parameter int BITS       = 32,
    parameter int RCP_CYCLES = RCP_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [BITS-1:0] fa,
    input  logic [BITS-1:0] fb,
    output logic            busy,
    output logic            done,
    output logic [BITS-1:0] fz,
    output logic [BITS-1:0] add_a,
    output logic [BITS-1:0] add_b,
    output logic            add_sub,
    input  logic [BITS-1:0] add_z,
    output logic [BITS-1:0] mul_a,
    output logic [BITS-1:0] mul_b,
    input  logic [BITS-1:0] mul_z,
    output logic [BITS-1:0] rcp_fa,
    output logic            rcp_en,
    input  logic [BITS-1:0] rcp_fadd_a,
    input  logic [BITS-1:0] rcp_fadd_b,
    input  logic [BITS-1:0] rcp_fmul_a,
    input  logic [BITS-1:0] rcp_fmul_b,
    input  logic [BITS-1:0] rcp_fz
);

    localparam int            CW       = (RCP_CYCLES > 1) ? $clog2(RCP_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(RCP_CYCLES - 1);

    state_e          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [BITS-1:0] fa_q, fa_d;
    logic [BITS-1:0] fb_q, fb_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BITS-1:0] fz_q, fz_d;
    logic            done_q, done_d;
    logic            accept;

`ifdef FPU_BACK_TO_BACK_EN
    // Idle is enough: a start in the done cycle chains straight on.
    assign accept = start && (state_q == ST_IDLE);
`else
    // The done cycle is a dead cycle for new requests.
    assign accept = start && (state_q == ST_IDLE) && !done_q;
`endif

    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;
    assign fz     = fz_q;
    assign rcp_fa = fa_q;
    assign rcp_en = (state_q == ST_RCP);

    fpu_operand_mux #(.BITS(BITS)) u_mux (
        .sel_client (state_q == ST_RCP),
        .fa_l       (fa_q),
        .fb_l       (fb_q),
        .sub_l      (op_q == FOP_SUB),
        .rcp_fadd_a (rcp_fadd_a),
        .rcp_fadd_b (rcp_fadd_b),
        .rcp_fmul_a (rcp_fmul_a),
        .rcp_fmul_b (rcp_fmul_b),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_sub    (add_sub),
        .mul_a      (mul_a),
        .mul_b      (mul_b)
    );

    // Next-state: accept/latch in IDLE, capture unit or client result at completion.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        fa_d    = fa_q;
        fb_d    = fb_q;
        cnt_d   = cnt_q;
        fz_d    = fz_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d    = op;
                    fa_d    = fa;
                    fb_d    = fb;
                    cnt_d   = '0;
                    state_d = (op == FOP_RCP) ? ST_RCP : ST_EXEC;
                end
            end
            ST_EXEC: begin
                fz_d    = (op_q == FOP_MUL) ? mul_z : add_z;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_RCP: begin
                if (cnt_q == CNT_LAST) begin
                    // Client wraps its own step counter on this same edge.
                    fz_d    = rcp_fz;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Controller registers; clr aborts any pass without a done.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            fa_q    <= '0;
            fb_q    <= '0;
            cnt_q   <= '0;
            fz_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            fa_q    <= fa_d;
            fb_q    <= fb_d;
            cnt_q   <= cnt_d;
            fz_q    <= fz_d;
            done_q  <= done_d;
        end
    end

endmodule
